// File: rtl/mem_stage.sv
//-----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage between exe_stage and the write-back stage.
//   Holds one instruction from EXE and waits for its data-SRAM response if it
//   is a load or store. Load data is extended by width and byte offset.
//   Multiply/divide results are selected by the op flags. The final result is
//   forwarded to decode. Outstanding SRAM transactions are counted so that
//   responses belonging to flushed instructions are silently discarded.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   ws_allowin            WB can accept an instruction
//   ms_allowin            MEM can accept an instruction
//   es_to_ms_valid/_bus   instruction offered by EXE
//   es_mem_req_fire       EXE data request accepted this cycle
//   mul_result            64-bit product for the resident instruction
//   div_quotient/_rem     divider results for the resident instruction
//   data_sram_data_ok     one in-order SRAM response this cycle
//   data_sram_rdata       response data
//   excp_flush/ertn_flush pipeline flush
//   ms_to_ws_valid/_bus   instruction offered to WB
//   ms_forward            {data_pending, final_result, dest, gr_we, ms_valid}
//   ms_excp_pending       resident instruction carries an exception
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 104,
    parameter int MS_TO_WS_BUS_WD = 119,
    parameter int MS_FORWARD_WD   = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_mem_req_fire,
    input  logic [63:0]                mul_result,
    input  logic [31:0]                div_quotient,
    input  logic [31:0]                div_remainder,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       excp_flush,
    input  logic                       ertn_flush,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    output logic                       ms_excp_pending
);

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic                       r_buf_valid;
    logic [31:0]                r_buf_data;
    logic [1:0]                 r_out_cnt;
    logic [1:0]                 r_drop_cnt;

    // resident instruction fields
    logic [31:0] w_pc;
    logic [31:0] w_alu_result;
    logic [4:0]  w_dest;
    logic        w_gr_we;
    logic        w_res_from_mem;
    logic        w_ld_hu, w_ld_h, w_ld_bu, w_ld_b, w_ld_w;
    logic        w_mem_we;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_mul_div_op;
    logic        w_excp;
    logic [15:0] w_excp_num;

    assign w_pc           = r_bus[31:0];
    assign w_alu_result   = r_bus[63:32];
    assign w_dest         = r_bus[68:64];
    assign w_gr_we        = r_bus[69];
    assign w_res_from_mem = r_bus[70];
    assign w_ld_hu        = r_bus[74];
    assign w_ld_h         = r_bus[75];
    assign w_ld_bu        = r_bus[76];
    assign w_ld_b         = r_bus[77];
    assign w_ld_w         = r_bus[78];
    assign w_mem_we       = r_bus[79];
    assign w_addr_lo      = r_bus[81:80];
    assign w_mul_div_op   = r_bus[86:83];
    assign w_excp         = r_bus[87];
    assign w_excp_num     = r_bus[103:88];

    logic w_flush;
    logic w_mem_acc;
    logic w_ok_match;
    logic w_ready_go;
    logic w_leave;

    assign w_flush    = excp_flush | ertn_flush;
    // an excepting load/store never issued a request, so it waits for nothing
    assign w_mem_acc  = (w_res_from_mem | w_mem_we) & ~w_excp;
    // a response is ours only when no killed responses are still in flight
    assign w_ok_match = data_sram_data_ok & (r_drop_cnt == 2'd0);
    assign w_ready_go = ~w_mem_acc | r_buf_valid | w_ok_match;

    assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go;
    assign w_leave        = ms_to_ws_valid & ws_allowin;

    //-------------------------------------------------------------------------
    // load extension
    //-------------------------------------------------------------------------
    logic [31:0] w_ld_src;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_res;

    assign w_ld_src = r_buf_valid ? r_buf_data : data_sram_rdata;
    assign w_half   = w_addr_lo[1] ? w_ld_src[31:16] : w_ld_src[15:0];

    always_comb begin
        w_byte = w_ld_src[7:0];
        case (w_addr_lo)
            2'd0: w_byte = w_ld_src[7:0];
            2'd1: w_byte = w_ld_src[15:8];
            2'd2: w_byte = w_ld_src[23:16];
            2'd3: w_byte = w_ld_src[31:24];
            default: w_byte = w_ld_src[7:0];
        endcase
    end

    always_comb begin
        w_ld_res = w_ld_src;                      // ld_w and fallback
        if (w_ld_b)
            w_ld_res = {{24{w_byte[7]}}, w_byte};
        else if (w_ld_bu)
            w_ld_res = {24'd0, w_byte};
        else if (w_ld_h)
            w_ld_res = {{16{w_half[15]}}, w_half};
        else if (w_ld_hu)
            w_ld_res = {16'd0, w_half};
    end

    //-------------------------------------------------------------------------
    // result select
    //-------------------------------------------------------------------------
    logic [31:0] w_final_result;

    always_comb begin
        w_final_result = w_alu_result;
        if (w_res_from_mem & ~w_excp)
            w_final_result = w_ld_res;
        else if (w_mul_div_op[0])
            w_final_result = mul_result[31:0];
        else if (w_mul_div_op[1])
            w_final_result = mul_result[63:32];
        else if (w_mul_div_op[2])
            w_final_result = div_quotient;
        else if (w_mul_div_op[3])
            w_final_result = div_remainder;
    end

    //-------------------------------------------------------------------------
    // outputs
    //-------------------------------------------------------------------------
    logic w_data_pending;
    assign w_data_pending = r_ms_valid & w_res_from_mem & ~w_ready_go;

    assign ms_to_ws_bus    = {w_alu_result, w_excp_num, w_excp, w_gr_we,
                              w_dest, w_final_result, w_pc};
    assign ms_forward      = {w_data_pending, w_final_result, w_dest,
                              w_gr_we, r_ms_valid};
    assign ms_excp_pending = r_ms_valid & w_excp;

    //-------------------------------------------------------------------------
    // stage register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
            r_bus      <= '0;
        end else begin
            if (w_flush)
                r_ms_valid <= 1'b0;
            else if (ms_allowin)
                r_ms_valid <= es_to_ms_valid;
            if (!w_flush && es_to_ms_valid && ms_allowin)
                r_bus <= es_to_ms_bus;
        end
    end

    //-------------------------------------------------------------------------
    // data buffer: holds a response when WB is not ready in its arrival
    // cycle. Never overwritten while full.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (w_flush || w_leave) begin
            r_buf_valid <= 1'b0;
        end else if (w_ok_match && r_ms_valid && w_mem_acc &&
                     !ws_allowin && !r_buf_valid) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_sram_rdata;
        end
    end

    //-------------------------------------------------------------------------
    // outstanding / drop counters
    //-------------------------------------------------------------------------
    // Everything still in flight after this edge belongs to killed
    // instructions, including a request fired in the flush cycle. A response
    // arriving in the flush cycle is consumed now and is not counted.
    logic [2:0] w_drop_base;
    logic [2:0] w_drop_next;

    assign w_drop_base = {1'b0, r_out_cnt} + {2'd0, es_mem_req_fire};
    assign w_drop_next = (data_sram_data_ok && w_drop_base != 3'd0) ?
                         w_drop_base - 3'd1 : w_drop_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_cnt <= 2'd0;
        end else begin
            case ({es_mem_req_fire, data_sram_data_ok})
                2'b10: r_out_cnt <= r_out_cnt + 2'd1;
                // a stray response (e.g. after reset) must not underflow
                2'b01: if (r_out_cnt != 2'd0) r_out_cnt <= r_out_cnt - 2'd1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_drop_cnt <= 2'd0;
        else if (w_flush)
            r_drop_cnt <= w_drop_next[1:0];
        else if (data_sram_data_ok && r_drop_cnt != 2'd0)
            r_drop_cnt <= r_drop_cnt - 2'd1;
    end

    // store width and sign bits are consumed upstream
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, r_bus[73:71], r_bus[82], w_ld_w,
                           w_drop_next[2]};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of `exe_stage` and upstream of the write-back stage. It latches the EXE→MEM bus and waits for the data-SRAM response of the loads and stores that EXE issued. It extends load data, selects multiply/divide results, and forwards the final result toward decode. It also tracks outstanding SRAM transactions so that responses belonging to flushed instructions are discarded.

## Interface
- `ES_TO_MS_BUS_WD`, 104, EXE→MEM bus width.
- `MS_TO_WS_BUS_WD`, 119, MEM→WB bus width.
- `MS_FORWARD_WD`, 40, forward bus width.

- `clk`  in  1  clock; everything is sampled on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ws_allowin`  in  1  WB can accept an instruction.
- `ms_allowin`  out  1  MEM can accept an instruction.
- `es_to_ms_valid`  in  1  EXE offers an instruction.
- `es_to_ms_bus`  in  104  fields:
  - [31:0] pc; [63:32] alu_result; [68:64] dest; [69] gr_we; [70] res_from_mem
  - [71] st_h; [72] st_b; [73] st_w; [74] ld_hu; [75] ld_h; [76] ld_bu; [77] ld_b; [78] ld_w; [79] mem_we
  - [81:80] addr_lo; [82] mul_div_sign; [86:83] mul_div_op (0 mul_lo, 1 mul_hi, 2 div_q, 3 div_r); [87] excp; [103:88] excp_num
- `es_mem_req_fire`  in  1  EXE data request accepted this cycle (req && addr_ok).
- `mul_result`  in  64  product for the resident instruction.
- `div_quotient`  in  32  divider quotient.
- `div_remainder`  in  32  divider remainder.
- `data_sram_data_ok`  in  1  one response, in request order.
- `data_sram_rdata`  in  32  response data.
- `excp_flush`  in  1  exception flush.
- `ertn_flush`  in  1  ertn flush.
- `ms_to_ws_valid`  out  1  MEM offers an instruction to WB.
- `ms_to_ws_bus`  out  119  fields: [31:0] pc; [63:32] final_result; [68:64] dest; [69] gr_we; [70] excp; [86:71] excp_num; [118:87] vaddr (alu_result).
- `ms_forward`  out  40  fields: [0] ms_valid; [1] gr_we; [6:2] dest; [38:7] final_result; [39] data_pending.
- `ms_excp_pending`  out  1  `ms_valid && excp`; EXE suppresses new requests while this is high.

## Operation
**Memory access**
- `mem_acc = (res_from_mem | mem_we) & !excp`. Only such an instruction expects exactly one `data_ok`.

**Data buffer**
- `buf_valid` and `buf_data` capture a matched `data_ok` when the instruction cannot leave that cycle.
- `ms_ready_go = !mem_acc | buf_valid | (data_ok & drop_cnt==0)`.
- Load data source: `buf_valid ? buf_data : data_sram_rdata`.

**Load extension** (byte/half selected by `addr_lo`)
- ld_b / ld_bu: sign- / zero-extend the selected byte.
- ld_h / ld_hu: sign- / zero-extend the half selected by `addr_lo[1]`.
- ld_w: the full word.

**Result select**
- `final_result` priority: load > mul_lo (`mul_result[31:0]`) > mul_hi (`[63:32]`) > div_q > div_r > alu_result.
- Stores carry alu_result.

**Outstanding counter** `out_cnt` (2 bits)
- +1 on `es_mem_req_fire`, −1 on `data_ok`; both in one cycle leave it unchanged.
- Saturation never occurs by construction: at most 2 requests are outstanding.

**Drop counter** `drop_cnt` (2 bits)
- On flush: `drop_cnt <= out_cnt + es_mem_req_fire − data_ok`.
- While `drop_cnt > 0`, each `data_ok` decrements it and is never delivered or buffered.

**Flush** (`excp_flush | ertn_flush`)
- Next edge: `ms_valid <= 0` and `buf_valid <= 0`.
- `es_to_ms_valid` in the flush cycle is ignored.

**Handshake**
- `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go`.
- The bus register loads only when `es_to_ms_valid & ms_allowin`.

**Forwarding**
- `data_pending = ms_valid & res_from_mem & !ms_ready_go`.
- Decode stalls when `data_pending` is set and the destination matches.

## Timing
**Reset values**
- `ms_valid` = 0, `buf_valid` = 0, `out_cnt` = 0, `drop_cnt` = 0.
- Hence `ms_allowin` = 1, `ms_to_ws_valid` = 0, `ms_forward` = 0 in bit 0, `ms_excp_pending` = 0.
- The bus register is don't-care while `ms_valid` = 0.

**Latency**
- Non-memory instructions: 1 cycle in MEM.
- Memory instructions leave in the cycle `data_ok` arrives, or any later cycle via the buffer.

**Data buffer rules**
- Buffer set: `data_ok` matched & `ms_valid` & `mem_acc` & !`ws_allowin` & !`buf_valid`.
- Buffer cleared: the instruction leaves, or flush.
- A `data_ok` arriving while `buf_valid` = 1 with `drop_cnt` = 0 is a protocol error; the buffer is not overwritten.

**Flush boundaries**
- Flush in the same cycle as `data_ok` with `drop_cnt` = 0: that response belongs to the killed instruction and is not added to `drop_cnt`.
- Flush in the same cycle as `es_mem_req_fire`: that request is counted into `drop_cnt`.

**Reset mid-operation**
- All state clears immediately (asynchronous).
- Any late `data_ok` after reset is ignored because `out_cnt` = 0 and there is no resident memory instruction.

## Test plan
- **Load, byte, signed:** ld_b with addr_lo=2'b11; `data_ok` the cycle after entry with rdata=0x80FF_1234 → final_result=0xFFFF_FF80, `ms_to_ws_valid` for exactly one cycle.
- **Load, half, unsigned, WB stalled:** ld_hu with addr_lo=2'b10, rdata=0xBEEF_0000, `ws_allowin`=0 for 3 cycles → buffered; leaves when `ws_allowin`=1 with result 0x0000_BEEF; `data_pending`=0 after capture.
- **Flush with outstanding response:** load resident with `out_cnt`=1 and `excp_flush` pulse → `ms_valid`=0 next cycle; a later `data_ok` (rdata=0x1234_5678) produces no `ms_to_ws_valid`; `drop_cnt` returns to 0.
- **Flush with simultaneous new request:** flush and `es_mem_req_fire` in the same cycle with `out_cnt`=1 → `drop_cnt`=2; the next two `data_ok` are dropped; a following fresh ld_w returns its data correctly.
- **Mul/div select:** mul_hi with mul_result=0x1234_5678_9ABC_DEF0 → final_result=0x1234_5678. div_r with div_remainder=7 → 7. Each leaves after 1 cycle.
- **Exception and reset:** instruction with excp=1, res_from_mem=1 → no wait, `ms_excp_pending`=1, leaves without `data_ok`. Reset asserted mid-wait → all outputs at reset values within the same cycle.
